// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP     = 4;
    localparam logic [15:0] NOP_INS_DEF = 16'h0000;

    // Redirect targets are byte addresses; instructions are word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captured instruction, its PC+4 and a valid flag.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W  = 16,
    parameter int unsigned      INS_W   = 16,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [INS_W-1:0]  load_ins,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] pc,
    output logic              valid
);

    logic [INS_W-1:0]  ins_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;

    // Flush wins over hold so a redirect can kill a stalled slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ins_q   <= NOP_INS;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            ins_q   <= load_ins;
            pc_q    <= load_pc;
            valid_q <= 1'b1;
        end
    end

    assign ins   = ins_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives imem, fills IF/ID and
// handles stall, redirect, end-of-program and halt/resume.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       INS_W     = 16,
    parameter int unsigned       MEM_WORDS = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [INS_W-1:0]  NOP_INS   = INS_W'(NOP_INS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_ins,
    output logic [INS_W-1:0]  if_id_ins,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    localparam logic [ADDR_W:0]   MEM_END = (ADDR_W+1)'(MEM_WORDS * PC_STEP);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_WORDS * PC_STEP - PC_STEP);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_next, target;
    logic [15:0]       count_q;
    logic              capture, flush, target_oob, pc_in_range;

    assign target      = ADDR_W'(align_pc(32'(redirect_pc)));
    assign target_oob  = {1'b0, target} >= MEM_END;
    assign pc_in_range = {1'b0, pc_q} < MEM_END;
    assign pc_next     = pc_q + STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (redirect) begin
                    pc_d    = target;
                    flush   = 1'b1;
                    state_d = target_oob ? StHalted : StRun;
                end else if (halt_req) begin
                    flush   = 1'b1;
                    state_d = StHalted;
                end else if (!stall) begin
                    capture = 1'b1;
                    pc_d    = pc_next;
                    // No wrap: fetching the last word ends the program.
                    if (pc_q == LAST_PC) state_d = StHalted;
                end
            end
            StHalted: begin
                if (redirect) begin
                    pc_d  = target;
                    flush = 1'b1;
                    if (!target_oob) state_d = StRun;
                end else begin
                    // Under stall IF/ID keeps its word so downstream can drain.
                    flush = !stall;
                    if (resume && pc_in_range) state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INS_W  (INS_W),
        .NOP_INS(NOP_INS)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold    (!capture),
        .flush   (flush),
        .load_ins(imem_ins),
        .load_pc (pc_next),
        .ins     (if_id_ins),
        .pc      (if_id_pc),
        .valid   (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign halted      = (state_q == StHalted);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus random stimulus against a behavioural fetch model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt_req, resume;
    logic [15:0] redirect_pc, imem_addr, imem_ins, if_id_ins, if_id_pc, pc, fetch_count;
    logic        if_id_valid, halted;

    logic [15:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: "booting" is the one dead cycle after reset,
    // "stopped" means the sequencer is parked.
    int          m_pc, m_cnt;
    bit          m_booting, m_stopped, m_valid;
    logic [15:0] m_ins, m_ifpc;

    always #5 clk = ~clk;

    assign imem_ins = (imem_addr < 16'd64) ? mem[imem_addr[5:2]] : 16'hdead;

    fetch_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .resume     (resume),
        .imem_addr  (imem_addr),
        .imem_ins   (imem_ins),
        .if_id_ins  (if_id_ins),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid),
        .pc         (pc),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bubble();
        m_ins   = 16'h0000;
        m_ifpc  = 16'h0000;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input bit r, s, rd, input int rp, input bit h, rs);
        int t;
        t = rp - (rp % 4);
        if (r) begin
            m_pc = 0; m_cnt = 0; m_booting = 1; m_stopped = 0;
            bubble();
        end else if (m_booting) begin
            m_booting = 0;
        end else if (!m_stopped) begin
            if (rd) begin
                m_pc = t; bubble();
                m_stopped = (t >= 64);
            end else if (h) begin
                bubble(); m_stopped = 1;
            end else if (!s) begin
                m_ins   = mem[m_pc / 4];
                m_ifpc  = 16'(m_pc + 4);
                m_valid = 1;
                if (m_cnt < 65535) m_cnt++;
                if (m_pc == 60) m_stopped = 1;
                m_pc = (m_pc + 4) % 65536;
            end
        end else begin
            if (rd) begin
                m_pc = t; bubble();
                if (t < 64) m_stopped = 0;
            end else begin
                if (!s) bubble();
                if (rs && m_pc < 64) m_stopped = 0;
            end
        end
    endtask

    task automatic step(input bit r, s, rd, input logic [15:0] rp, input bit h, rs);
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = rp; halt_req = h; resume = rs;
        model_edge(r, s, rd, int'(rp), h, rs);
        @(posedge clk);
        #1;
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
        check_eq("if_id_ins", 32'(if_id_ins), 32'(m_ins));
        check_eq("if_id_pc", 32'(if_id_pc), 32'(m_ifpc));
        check_eq("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check_eq("halted", 32'(halted), 32'(m_stopped));
        check_eq("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        bit r, s, rd, h, rs;
        logic [15:0] rp;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        rst = 1; stall = 0; redirect = 0; redirect_pc = '0; halt_req = 0; resume = 0;

        // Reset, then BOOT and three captures.
        step(1, 0, 0, 16'h0, 0, 0);
        check_eq("rst_valid", 32'(if_id_valid), 32'd0);
        step(0, 0, 0, 16'h0, 0, 0);
        check_eq("boot_valid", 32'(if_id_valid), 32'd0);
        run(3);
        check_eq("tp1_ins", 32'(if_id_ins), 32'(mem[2]));
        check_eq("tp1_ifpc", 32'(if_id_pc), 32'd12);
        check_eq("tp1_pc", 32'(pc), 32'd12);
        check_eq("tp1_cnt", 32'(fetch_count), 32'd3);

        // Stall for two cycles at pc=8.
        step(1, 0, 0, 16'h0, 0, 0); step(0, 0, 0, 16'h0, 0, 0); run(2);
        step(0, 1, 0, 16'h0, 0, 0); step(0, 1, 0, 16'h0, 0, 0);
        check_eq("stall_pc", 32'(pc), 32'd8);
        check_eq("stall_cnt", 32'(fetch_count), 32'd2);
        run(1);
        check_eq("stall_rel_ins", 32'(if_id_ins), 32'(mem[2]));
        check_eq("stall_rel_ifpc", 32'(if_id_pc), 32'd12);

        // Unaligned redirect together with stall at pc=12.
        step(0, 1, 1, 16'h0007, 0, 0);
        check_eq("redir_pc", 32'(pc), 32'd4);
        check_eq("redir_valid", 32'(if_id_valid), 32'd0);
        run(1);
        check_eq("redir_ins", 32'(if_id_ins), 32'(mem[1]));
        check_eq("redir_ifpc", 32'(if_id_pc), 32'd8);

        // Run off the end of memory; resume must not restart.
        for (int i = 0; i < 40 && !halted; i++) run(1);
        check_eq("end_ins", 32'(if_id_ins), 32'(mem[15]));
        check_eq("end_ifpc", 32'(if_id_pc), 32'd64);
        run(1);
        check_eq("end_pc", 32'(pc), 32'd64);
        check_eq("end_valid", 32'(if_id_valid), 32'd0);
        step(0, 0, 0, 16'h0, 0, 1);
        check_eq("end_resume", 32'(halted), 32'd1);

        // halt_req at pc=8, then resume.
        step(1, 0, 0, 16'h0, 0, 0); step(0, 0, 0, 16'h0, 0, 0); run(2);
        step(0, 0, 0, 16'h0, 1, 0);
        check_eq("halt_state", 32'(halted), 32'd1);
        check_eq("halt_pc", 32'(pc), 32'd8);
        step(0, 0, 0, 16'h0, 0, 1);
        check_eq("resume_state", 32'(halted), 32'd0);
        run(1);
        check_eq("resume_ins", 32'(if_id_ins), 32'(mem[2]));

        // Reset while halted with nine fetches done.
        step(1, 0, 0, 16'h0, 0, 0); step(0, 0, 0, 16'h0, 0, 0); run(9);
        step(0, 0, 0, 16'h0, 1, 0);
        check_eq("pre_rst_cnt", 32'(fetch_count), 32'd9);
        step(1, 0, 0, 16'h0, 0, 0);
        check_eq("rst_cnt", 32'(fetch_count), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        step(0, 0, 0, 16'h0, 0, 0);
        run(1);
        check_eq("rst_word0", 32'(if_id_ins), 32'(mem[0]));

        // Random mix of all controls.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(99) < 1);
            s  = ($urandom_range(99) < 25);
            rd = ($urandom_range(99) < 10);
            rp = 16'($urandom_range(80));
            h  = ($urandom_range(99) < 5);
            rs = ($urandom_range(99) < 20);
            step(r, s, rd, rp, h, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
